regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32-entry register file between two writeback
//  requesters: A = ALU result, B = memory load return. Each requester gets a one-entry
//  holding slot. A round-robin arbiter drains the slots. Registered outputs drive the
//  register file directly: a one-hot write-enable vector, a write address and write data.
//  Register 0 is hard-wired to zero and is never enabled.
// PARAMETERS
//  NREG  32  number of architectural registers (one-hot width)
//  AW    5   register address width (log2 NREG)
//  DW    32  write data width
// PORTS
//  clk       in   1     single clock, rising edge
//  rst_n     in   1     asynchronous, active-low reset
//  a_valid   in   1     requester A offers a write
//  a_ready   out  1     slot A can accept; transfer = a_valid & a_ready at rising clk
//  a_addr    in   AW    destination register of A
//  a_data    in   DW    write data of A
//  b_valid   in   1     requester B offers a write
//  b_ready   out  1     slot B can accept
//  b_addr    in   AW    destination register of B
//  b_data    in   DW    write data of B
//  stall     in   1     pipeline hold: no grants while high
//  wr_en     out  NREG  one-hot register write enable; bit i = register i (registered)
//  wr_addr   out  AW    address of the current write (registered)
//  wr_data   out  DW    data of the current write (registered)
//  conflict  out  1     pulse: both slots held the same nonzero address in a grant cycle
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - slots empty; rr=0 (A preferred).
//   - wr_en=0, wr_addr=0, wr_data=0, conflict=0. These clear immediately, so an in-flight write is cancelled.
//   - Slot contents are discarded.
//  Slot: full flag plus addr/data.
//   - x_ready = ~full_x | grant_x.
//   - grant_x is a function of the slot flags, rr and stall only, so there is no combinational path from valid to ready.
//   - On accept, the slot loads at the edge. Accept and drain in the same cycle are legal: the slot stays full with the new entry.
//  Arbitration (per cycle, stall=0):
//   - only A full -> grant A; only B full -> grant B.
//   - both full -> grant A if rr=0, else B. rr <= ~granted side after a both-full grant only.
//   - at most one grant per cycle.
//  Output register at the edge after a grant:
//   - wr_en <= (addr==0) ? 0 : 1<<addr; wr_addr/wr_data <= slot contents.
//   - With no grant: wr_en <= 0, and wr_addr/wr_data hold their values.
//  Addr 0 is consumed (slot drained, ready returns) but produces no enable.
//  conflict <= both full & a_addr_slot==b_addr_slot & addr!=0 at the grant edge. The lower-priority write lands one cycle later, so the last granted write wins.
//  stall=1: no grants; wr_en <= 0; slots may still fill if empty; rr unchanged.
//  Latency: accept at edge N; earliest grant in cycle N+1; wr_en valid after edge N+1; the register file writes at edge N+2.
//  Throughput: one write per cycle total. A single uncontended requester sustains 1/cycle.
// STRUCTURE
//  Shared package regfile_pkg:
//   - constants NREG, AW, DW, REG_ZERO=0
//   - rr encoding RR_A=0, RR_B=1
//  Sub-module wb_hold_slot: one-entry buffer with full flag, load/drain, and the ready equation. Instantiated twice.
//  The top level holds the arbiter, the rr flop, the one-hot decode and the output registers.
// TESTING
//  1. Reset mid-stream: A writes r5 and grant issues, then rst_n=0 before the next edge -> wr_en=0 at once; a_ready=1 after release.
//  2. A only, back-to-back r1..r4 data 0x11..0x44 -> wr_en bits 1,2,3,4 on consecutive cycles; a_ready stays 1.
//  3. A and B both full every cycle, rr=0 -> grant order A,B,A,B; wr_addr alternates.
//  4. A=r7/0xAAAA and B=r7/0xBBBB both full -> conflict=1 for one cycle; A written first, then B; final value 0xBBBB.
//  5. A writes r0/0xFFFF -> slot drains, wr_en=0, a_ready reasserts the next cycle.
//  6. stall=1 for 3 cycles with both slots full -> wr_en=0 and both readies 0. After release: A then B granted on consecutive cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // Round-robin pointer: which side wins the next both-full cycle.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

endpackage : regfile_pkg

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot. Ready depends only on the slot flag and
// the arbiter grant, never on the requester's valid.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          grant_i,
  output logic          ready_o,
  output logic          full_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          load;

  assign ready_o = ~full_q | grant_i;
  assign load    = valid_i & ready_o;

  // Load wins over drain so a same-cycle accept keeps the slot full.
  always_comb begin
    full_d = full_q;
    if (load)         full_d = 1'b1;
    else if (grant_i) full_d = 1'b0;
  end

  // Slot flag and payload; payload only changes on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (load) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule : wb_hold_slot

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and load-return (B)
// writeback paths with round-robin arbitration and registered one-hot outputs.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  input  logic            stall,
  output logic [NREG-1:0] wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            conflict
);

  logic          a_full, b_full;
  logic [AW-1:0] a_slot_addr, b_slot_addr;
  logic [DW-1:0] a_slot_data, b_slot_data;
  logic          grant_a, grant_b, both_full;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [NREG-1:0] sel_onehot;

  rr_e             rr_q;
  logic [NREG-1:0] wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            conflict_q;

  wb_hold_slot u_slot_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (a_valid),
    .addr_i  (a_addr),
    .data_i  (a_data),
    .grant_i (grant_a),
    .ready_o (a_ready),
    .full_o  (a_full),
    .addr_o  (a_slot_addr),
    .data_o  (a_slot_data)
  );

  wb_hold_slot u_slot_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (b_valid),
    .addr_i  (b_addr),
    .data_i  (b_data),
    .grant_i (grant_b),
    .ready_o (b_ready),
    .full_o  (b_full),
    .addr_o  (b_slot_addr),
    .data_o  (b_slot_data)
  );

  // Grants look only at slot flags, rr and stall; at most one side wins.
  always_comb begin
    both_full = a_full & b_full;
    grant_a   = ~stall & a_full & (~b_full | (rr_q == RR_A));
    grant_b   = ~stall & b_full & (~a_full | (rr_q == RR_B));
    sel_addr  = grant_a ? a_slot_addr : b_slot_addr;
    sel_data  = grant_a ? a_slot_data : b_slot_data;
    sel_onehot = (sel_addr == REG_ZERO) ? '0 : (NREG'(1) << sel_addr);
  end

  // Round-robin pointer and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= RR_A;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (both_full && !stall) rr_q <= grant_a ? RR_B : RR_A;
      conflict_q <= 1'b0;
      if (grant_a || grant_b) begin
        wr_en_q    <= sel_onehot;
        wr_addr_q  <= sel_addr;
        wr_data_q  <= sel_data;
        conflict_q <= both_full && (a_slot_addr == b_slot_addr)
                      && (a_slot_addr != REG_ZERO);
      end else begin
        wr_en_q <= '0;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign conflict = conflict_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, stall;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [31:0] wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        conflict;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    stall   = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    stall   = 1'b0;
    step();
    step();
    chk("rst_wr_en",    wr_en, 32'h0);
    chk("rst_wr_addr",  32'(wr_addr), 32'h0);
    chk("rst_wr_data",  wr_data, 32'h0);
    chk("rst_conflict", 32'(conflict), 32'h0);
    chk("rst_a_ready",  32'(a_ready), 32'h1);
    chk("rst_b_ready",  32'(b_ready), 32'h1);
    rst_n = 1'b1;

    // 1. reset cancels an in-flight write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55;
    step();
    a_valid = 1'b0;
    step();
    chk("t1_wr_en",   wr_en, 32'h0000_0020);
    chk("t1_wr_data", wr_data, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_wr_en",   wr_en, 32'h0);
    chk("t1_async_wr_addr", 32'(wr_addr), 32'h0);
    chk("t1_async_wr_data", wr_data, 32'h0);
    #2 rst_n = 1'b1;
    step();
    chk("t1_a_ready", 32'(a_ready), 32'h1);
    chk("t1_idle_en", wr_en, 32'h0);

    // 2. A only, back-to-back r1..r4
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1'b1;
      a_addr  = 5'(i);
      a_data  = 32'(i * 32'h11);
      step();
      chk("t2_a_ready", 32'(a_ready), 32'h1);
      if (i > 1) begin
        chk("t2_wr_en",   wr_en, 32'h1 << (i - 1));
        chk("t2_wr_data", wr_data, 32'((i - 1) * 32'h11));
      end
    end
    a_valid = 1'b0;
    step();
    chk("t2_wr_en_last",   wr_en, 32'h0000_0010);
    chk("t2_wr_data_last", wr_data, 32'h44);
    step();
    chk("t2_drained", wr_en, 32'h0);

    // 3. both requesters continuously valid: A,B,A,B
    do_reset();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0;
    step();
    chk("t3_a_ready", 32'(a_ready), 32'h1);
    chk("t3_b_ready", 32'(b_ready), 32'h0);
    step(); chk("t3_g1", 32'(wr_addr), 32'd10);
    step(); chk("t3_g2", 32'(wr_addr), 32'd11);
    step(); chk("t3_g3", 32'(wr_addr), 32'd10);
    step(); chk("t3_g4", 32'(wr_addr), 32'd11);
    chk("t3_g4_en", wr_en, 32'h0000_0800);
    a_valid = 1'b0; b_valid = 1'b0;
    step(); chk("t3_d1", 32'(wr_addr), 32'd10);
    step(); chk("t3_d2", 32'(wr_addr), 32'd11);
    step(); chk("t3_d3", wr_en, 32'h0);

    // 4. same destination in both slots
    do_reset();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t4_conflict1", 32'(conflict), 32'h1);
    chk("t4_en1",   wr_en, 32'h0000_0080);
    chk("t4_data1", wr_data, 32'hAAAA);
    step();
    chk("t4_conflict2", 32'(conflict), 32'h0);
    chk("t4_en2",   wr_en, 32'h0000_0080);
    chk("t4_data2", wr_data, 32'hBBBB);
    step();
    chk("t4_en3", wr_en, 32'h0);

    // 5. write to r0 is consumed without an enable
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
    step();
    a_valid = 1'b0;
    step();
    chk("t5_wr_en",   wr_en, 32'h0);
    chk("t5_wr_data", wr_data, 32'hFFFF);
    stall = 1'b1;
    #1;
    chk("t5_a_ready_empty", 32'(a_ready), 32'h1);
    stall = 1'b0;

    // 6. stall holds both full slots, then A then B
    do_reset();
    stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_stall_en", wr_en, 32'h0);
      chk("t6_stall_a_ready", 32'(a_ready), 32'h0);
      chk("t6_stall_b_ready", 32'(b_ready), 32'h0);
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    chk("t6_g1_en",   wr_en, 32'h0000_1000);
    chk("t6_g1_data", wr_data, 32'hC);
    step();
    chk("t6_g2_en",   wr_en, 32'h0000_2000);
    chk("t6_g2_data", wr_data, 32'hD);
    step();
    chk("t6_idle", wr_en, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
